// File: rtl/param_block_delay.sv
// rtl/param_block_delay.sv - block delay line: circular RAM buffer with one-block-per-burst write gating
module param_block_delay #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 12288,
    parameter int AW    = 14,
    parameter int LEN_W = 14
) (
    input  logic             clock,
    input  logic             aclr_n,
    input  logic             data_write,
    input  logic [WIDTH-1:0] data_in,
    input  logic [LEN_W-1:0] block_len,
    input  logic             data_read,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             actual_fifo_we,
    output logic [AW:0]      usedw,
    output logic             full,
    output logic             empty,
    output logic             block_done,
    output logic [7:0]       block_count,
    output logic             wr_overflow,
    output logic             rd_underflow
);

    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        GAP
    } state_t;

    state_t            state, state_nxt;
    logic [CW-1:0]     len_q, len_nxt;
    logic [CW-1:0]     wcnt, wcnt_nxt;
    logic [CW-1:0]     len_eff;
    logic              done_nxt;
    logic              rd_acc;
    logic [AW-1:0]     wptr, rptr;
    logic [WIDTH-1:0]  mem [DEPTH];

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Oversized requests are trimmed to what the buffer can ever hold
    assign len_eff = (32'(block_len) > 32'(DEPTH)) ? CW'(DEPTH) : CW'(block_len);

    assign full   = (usedw == CW'(DEPTH));
    assign empty  = (usedw == '0);
    assign rd_acc = data_read & ~empty;

    always_comb begin
        state_nxt      = state;
        len_nxt        = len_q;
        wcnt_nxt       = wcnt;
        done_nxt       = 1'b0;
        actual_fifo_we = 1'b0;
        case (state)
            IDLE: begin
                if (aclr_n && data_write && !full && block_len != '0) begin
                    actual_fifo_we = 1'b1;
                    len_nxt        = len_eff;
                    wcnt_nxt       = CW'(1);
                    if (len_eff == CW'(1)) begin
                        done_nxt  = 1'b1;
                        state_nxt = GAP;
                    end else begin
                        state_nxt = FILL;
                    end
                end
            end
            FILL: begin
                if (aclr_n && data_write && !full) begin
                    actual_fifo_we = 1'b1;
                    wcnt_nxt       = wcnt + CW'(1);
                    if (wcnt == len_q - CW'(1)) begin
                        done_nxt  = 1'b1;
                        state_nxt = GAP;
                    end
                end
            end
            GAP: begin
                // A held write request must drop for a cycle before the next block
                if (!data_write) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            state        <= IDLE;
            len_q        <= '0;
            wcnt         <= '0;
            wptr         <= '0;
            rptr         <= '0;
            usedw        <= '0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            block_done   <= 1'b0;
            block_count  <= '0;
            wr_overflow  <= 1'b0;
            rd_underflow <= 1'b0;
        end else begin
            state      <= state_nxt;
            len_q      <= len_nxt;
            wcnt       <= wcnt_nxt;
            block_done <= done_nxt;
            data_valid <= rd_acc;
            if (done_nxt) block_count <= block_count + 8'd1;
            if (actual_fifo_we) wptr <= ptr_inc(wptr);
            if (rd_acc) begin
                rptr     <= ptr_inc(rptr);
                data_out <= mem[rptr];
            end
            case ({actual_fifo_we, rd_acc})
                2'b10:   usedw <= usedw + CW'(1);
                2'b01:   usedw <= usedw - CW'(1);
                default: usedw <= usedw;
            endcase
            if (data_write && full && state != GAP) wr_overflow <= 1'b1;
            if (data_read && empty) rd_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (actual_fifo_we) mem[wptr] <= data_in;
    end

endmodule

// File: tb/tb_param_block_delay.sv
// tb/tb_param_block_delay.sv - randomized self-checking bench for param_block_delay
module tb_param_block_delay;
    localparam int WIDTH = 8;
    localparam int DEPTH = 12288;
    localparam int AW    = 14;
    localparam int LEN_W = 15;

    logic             clock = 1'b0;
    logic             aclr_n = 1'b0;
    logic             data_write = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic [LEN_W-1:0] block_len = '0;
    logic             data_read = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             data_valid, actual_fifo_we, full, empty, block_done;
    logic [AW:0]      usedw;
    logic [7:0]       block_count;
    logic             wr_overflow, rd_underflow;

    int n_checks = 0;
    int n_pass   = 0;

    param_block_delay #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .LEN_W(LEN_W)) dut (
        .clock(clock), .aclr_n(aclr_n), .data_write(data_write), .data_in(data_in),
        .block_len(block_len), .data_read(data_read), .data_out(data_out),
        .data_valid(data_valid), .actual_fifo_we(actual_fifo_we), .usedw(usedw),
        .full(full), .empty(empty), .block_done(block_done), .block_count(block_count),
        .wr_overflow(wr_overflow), .rd_underflow(rd_underflow)
    );

    always #5 clock = ~clock;

    // Behavioural model: a queue of stored words plus the open block's remaining length
    logic [WIDTH-1:0] mq[$];
    int               m_left  = 0;
    bit               m_gap   = 0;
    logic [WIDTH-1:0] m_dout  = '0;
    bit               m_valid = 0;
    bit               m_done  = 0;
    logic [7:0]       m_count = '0;
    bit               m_ovf   = 0;
    bit               m_unf   = 0;

    always @(posedge clock or negedge aclr_n) begin
        bit gap_pre, idle, mfull, mempty, we, re;
        if (!aclr_n) begin
            mq.delete();
            m_left = 0; m_gap = 0; m_dout = '0; m_valid = 0;
            m_done = 0; m_count = '0; m_ovf = 0; m_unf = 0;
        end else begin
            gap_pre = m_gap;
            idle    = !m_gap && m_left == 0;
            mfull   = mq.size() == DEPTH;
            mempty  = mq.size() == 0;
            we = data_write && !mfull && ((idle && block_len != 0) || m_left != 0);
            re = data_read && !mempty;
            m_done = 0;
            if (data_write && mfull && !gap_pre) m_ovf = 1;
            if (data_read && mempty) m_unf = 1;
            m_valid = re;
            if (re) m_dout = mq.pop_front();
            if (we) begin
                mq.push_back(data_in);
                if (idle) m_left = ((int'(block_len) > DEPTH) ? DEPTH : int'(block_len)) - 1;
                else      m_left = m_left - 1;
                if (m_left == 0) begin
                    m_done  = 1;
                    m_count = m_count + 8'd1;
                    m_gap   = 1;
                end
            end
            if (gap_pre && !data_write) m_gap = 0;
        end
    end

    always @(negedge clock) begin
        logic [37:0] exp_v, act_v;
        bit exp_we;
        exp_we = aclr_n && data_write && mq.size() != DEPTH &&
                 ((!m_gap && m_left == 0 && block_len != 0) || m_left != 0);
        exp_v = {m_dout, m_valid, exp_we, 15'(mq.size()), mq.size() == DEPTH,
                 mq.size() == 0, m_done, m_count, m_ovf, m_unf};
        act_v = {data_out, data_valid, actual_fifo_we, usedw, full, empty,
                 block_done, block_count, wr_overflow, rd_underflow};
        n_checks++;
        if (act_v === exp_v) n_pass++;
        else $display("FAIL cycle_outputs t=%0t: got %h expected %h", $time, act_v, exp_v);
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic drive(input bit dw, input logic [WIDTH-1:0] din,
                         input logic [LEN_W-1:0] bl, input bit dr);
        data_write = dw; data_in = din; block_len = bl; data_read = dr;
        @(posedge clock);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        while (mq.size() != 0 && n < 20000) begin
            drive(0, '0, 1, 1);
            n++;
        end
        chk("drain_bound", mq.size(), 0);
    endtask

    initial begin
        logic [WIDTH-1:0] basic_in [6] = '{8'd1, 8'd0, 8'd1, 8'd1, 8'd0, 8'd0};
        logic [WIDTH-1:0] basic_out[4] = '{8'd1, 8'd0, 8'd1, 8'd1};
        logic [7:0] c0;

        repeat (3) @(posedge clock);
        #1 aclr_n = 1'b1;
        chk("reset_usedw", usedw, 0);
        chk("reset_empty", empty, 1);
        chk("reset_count", block_count, 0);

        for (int i = 0; i < 6; i++) drive(1, basic_in[i], 4, 0);
        drive(0, '0, 4, 0);
        chk("basic_usedw", usedw, 4);
        chk("basic_count", block_count, 1);
        for (int i = 0; i < 4; i++) begin
            drive(0, '0, 4, 1);
            chk("basic_rd_data", data_out, basic_out[i]);
            chk("basic_rd_valid", data_valid, 1);
        end
        drive(0, '0, 4, 0);
        chk("basic_valid_low", data_valid, 0);
        chk("basic_hold", data_out, 1);
        chk("basic_empty", empty, 1);

        for (int i = 0; i < 6147; i++) drive(1, WIDTH'($urandom), (i < 10) ? 15'd6144 : 15'd3, 0);
        drive(0, '0, 6144, 0);
        chk("rearm_usedw", usedw, 6144);
        chk("rearm_count", block_count, 2);
        for (int i = 0; i < 6147; i++) drive(1, WIDTH'($urandom), 6144, 0);
        drive(0, '0, 6144, 0);
        chk("full_usedw", usedw, 12288);
        chk("full_flag", full, 1);
        chk("full_count", block_count, 3);

        drive(1, 8'h11, 5, 0);
        drive(1, 8'h22, 5, 0);
        chk("ovf_flag", wr_overflow, 1);
        chk("ovf_usedw", usedw, 12288);
        drive(1, 8'h33, 5, 1);
        chk("full_rd_wr_refused", usedw, 12287);
        drive(1, 8'h44, 5, 0);
        chk("slot_freed_write", usedw, 12288);
        drive(0, '0, 5, 0);

        for (int i = 0; i < 3000; i++)
            drive(1'($urandom), WIDTH'($urandom), LEN_W'(1 + $urandom % 50), 1'($urandom));
        for (int i = 0; i < 120; i++) drive(1, WIDTH'($urandom), 10, 1);
        drive(0, '0, 10, 0);
        drain();

        drive(0, '0, 1, 1);
        chk("unf_flag", rd_underflow, 1);
        chk("unf_valid", data_valid, 0);
        chk("unf_empty", empty, 1);

        repeat (3) drive(1, 8'h5A, 0, 0);
        chk("len0_usedw", usedw, 0);
        drive(0, '0, 0, 0);

        c0 = m_count;
        drive(1, 8'hA5, 1, 0);
        chk("len1_done", block_done, 1);
        chk("len1_usedw", usedw, 1);
        drive(1, 8'h3C, 1, 0);
        chk("len1_done_pulse", block_done, 0);
        chk("len1_gap_refuse", usedw, 1);
        chk("len1_count", block_count, 8'(c0 + 8'd1));

        drive(0, '0, 30, 0);
        for (int i = 0; i < 20; i++) begin
            drive(1, WIDTH'($urandom), 30, 1);
            chk("simul_usedw", usedw, 1);
        end
        for (int i = 0; i < 10; i++) drive(1, WIDTH'($urandom), 30, 1);
        drive(0, '0, 30, 0);
        drain();

        c0 = m_count;
        for (int i = 0; i < 12290; i++) drive(1, WIDTH'($urandom), 15'd20000, 0);
        drive(0, '0, 15'd20000, 0);
        chk("clamp_usedw", usedw, 12288);
        chk("clamp_count", block_count, 8'(c0 + 8'd1));
        drain();

        drive(0, '0, 6144, 0);
        for (int i = 0; i < 100; i++) drive(1, WIDTH'($urandom), 6144, 0);
        aclr_n = 1'b0;
        #1;
        chk("rst_usedw", usedw, 0);
        chk("rst_count", block_count, 0);
        chk("rst_valid", data_valid, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_we", actual_fifo_we, 0);
        chk("rst_empty", empty, 1);
        repeat (2) @(posedge clock);
        #1 aclr_n = 1'b1;
        repeat (3) drive(1, WIDTH'($urandom), 3, 0);
        drive(0, '0, 3, 0);
        chk("post_rst_count", block_count, 1);
        chk("post_rst_usedw", usedw, 3);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
